// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } seq_state_t;

  localparam int MIN_LEN = 2;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_hist_shift.sv
// Serial history shift register with a saturating fill counter.
// Outputs show history/fill as they will be once the current bit is accepted.
module seq_hist_shift #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               vld_i,
  input  logic               bit_i,
  output logic [MAX_LEN-1:0] hist_o,
  output logic [LEN_W-1:0]   fill_o
);

  localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  assign hist_o = {hist_q[MAX_LEN-2:0], bit_i};
  assign fill_o = (fill_q == FULL) ? fill_q : fill_q + LEN_W'(1);

  // Clear wins over a shift so a consumed match bit never survives.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (vld_i) begin
      hist_d = hist_o;
      fill_d = fill_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial bit-pattern detector with overlap control,
// registered match pulse and saturating match counter.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           In,
  input  logic                           in_valid,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           cnt_clr,
  output logic                           Out,
  output logic [CNT_W-1:0]               match_cnt,
  output logic                           cfg_err,
  output logic                           armed
);

  localparam int LEN_W = len_width(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  seq_state_t         state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q, out_q, err_q, armed_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] hist_nxt, mask;
  logic [LEN_W-1:0]   fill_nxt;
  logic               cfg_ok, take_bit, match, hist_clr;

  assign cfg_ok   = (cfg_len >= MIN_L) && (cfg_len <= MAX_L);
  // A config load in the same cycle drops the incoming bit.
  assign take_bit = in_valid && !cfg_load && (state_q == RUN);
  assign hist_clr = cfg_load || (match && !ovl_q);

  seq_hist_shift #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_hist (
    .clk   (clk),
    .rst   (rst),
    .clr_i (hist_clr),
    .vld_i (take_bit),
    .bit_i (In),
    .hist_o(hist_nxt),
    .fill_o(fill_nxt)
  );

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_q));
  end

  assign match = take_bit && (fill_nxt >= len_q) && (((hist_nxt ^ pat_q) & mask) == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                      cnt_d = match ? CNT_W'(1) : '0;
    else if (match && (cnt_q != '1))  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= UNCFG;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      out_q <= match;
      cnt_q <= cnt_d;
      if (cfg_load) begin
        if (cfg_ok) begin
          state_q <= RUN;
          pat_q   <= cfg_pattern;
          len_q   <= cfg_len;
          ovl_q   <= cfg_overlap;
          err_q   <= 1'b0;
          armed_q <= 1'b1;
        end else begin
          state_q <= UNCFG;
          err_q   <= 1'b1;
          armed_q <= 1'b0;
        end
      end
    end
  end

  assign Out       = out_q;
  assign match_cnt = cnt_q;
  assign cfg_err   = err_q;
  assign armed     = armed_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed table-driven bench for seq_det_prog; a CNT_W=2 copy shares all inputs.
module tb_seq_det_prog;

  typedef struct {
    string      tag;
    logic       rst_n;
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       v;
    logic       din;
    logic       clr;
    logic       e_out;
    int         e_cnt8;
    int         e_cnt2;
    logic       e_err;
    logic       e_arm;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       In = 1'b0, in_valid = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0, cnt_clr = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;

  logic       o8, err8, arm8, o2, err2, arm2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  int row_idx = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  seq_det_prog #(.MAX_LEN(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .In(In), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .Out(o8), .match_cnt(cnt8), .cfg_err(err8), .armed(arm8)
  );

  seq_det_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .In(In), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .Out(o2), .match_cnt(cnt2), .cfg_err(err2), .armed(arm2)
  );

  task automatic add(input string tag, input logic rst_n, input logic ld, input logic [7:0] pat,
                     input logic [3:0] len, input logic ovl, input logic v, input logic din,
                     input logic clr, input logic e_out, input int e_cnt8, input int e_cnt2,
                     input logic e_err, input logic e_arm);
    vec_t r;
    r.tag = tag; r.rst_n = rst_n; r.ld = ld; r.pat = pat; r.len = len; r.ovl = ovl;
    r.v = v; r.din = din; r.clr = clr; r.e_out = e_out; r.e_cnt8 = e_cnt8;
    r.e_cnt2 = e_cnt2; r.e_err = e_err; r.e_arm = e_arm;
    tbl.push_back(r);
  endtask

  // Shorthand for a plain data bit with no configuration activity.
  task automatic bit_row(input string tag, input logic v, input logic din, input logic e_out,
                         input int e8, input int e2, input logic e_err, input logic e_arm);
    add(tag, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, v, din, 1'b0, e_out, e8, e2, e_err, e_arm);
  endtask

  task automatic chk(input string tag, input string what, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] %s: got %0d, expected %0d", tag, row_idx, what, act, exp);
    end
  endtask

  task automatic apply(input vec_t r);
    rst = r.rst_n; cfg_load = r.ld; cfg_pattern = r.pat; cfg_len = r.len;
    cfg_overlap = r.ovl; in_valid = r.v; In = r.din; cnt_clr = r.clr;
    @(posedge clk);
    #1;
    chk(r.tag, "Out",        int'(o8),   int'(r.e_out));
    chk(r.tag, "match_cnt",  int'(cnt8), r.e_cnt8);
    chk(r.tag, "cfg_err",    int'(err8), int'(r.e_err));
    chk(r.tag, "armed",      int'(arm8), int'(r.e_arm));
    chk(r.tag, "Out_w2",     int'(o2),   int'(r.e_out));
    chk(r.tag, "cnt_w2",     int'(cnt2), r.e_cnt2);
    chk(r.tag, "cfg_err_w2", int'(err2), int'(r.e_err));
    chk(r.tag, "armed_w2",   int'(arm2), int'(r.e_arm));
    row_idx++;
  endtask

  task automatic run_table();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    // Reset, overlap on with junk above len, overlap off, gaps, load-drops-bit, bad lengths.
    add("reset", 0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("t1_load", 1, 1, 8'hFB, 4'd4, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    bit_row("t1", 1, 1, 0, 0, 0, 0, 1);
    bit_row("t1", 1, 0, 0, 0, 0, 0, 1);
    bit_row("t1", 1, 1, 0, 0, 0, 0, 1);
    bit_row("t1", 1, 1, 1, 1, 1, 0, 1);
    bit_row("t1", 1, 0, 0, 1, 1, 0, 1);
    bit_row("t1", 1, 1, 0, 1, 1, 0, 1);
    bit_row("t1", 1, 1, 1, 2, 2, 0, 1);
    add("t2_load", 1, 1, 8'h0B, 4'd4, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    bit_row("t2", 1, 1, 0, 0, 0, 0, 1);
    bit_row("t2", 1, 0, 0, 0, 0, 0, 1);
    bit_row("t2", 1, 1, 0, 0, 0, 0, 1);
    bit_row("t2", 1, 1, 1, 1, 1, 0, 1);
    bit_row("t2", 1, 0, 0, 1, 1, 0, 1);
    bit_row("t2", 1, 1, 0, 1, 1, 0, 1);
    bit_row("t2", 1, 1, 0, 1, 1, 0, 1);
    add("t3_load", 1, 1, 8'h0B, 4'd4, 1, 0, 0, 0, 0, 1, 1, 0, 1);
    bit_row("t3", 1, 1, 0, 1, 1, 0, 1);
    bit_row("t3", 0, 0, 0, 1, 1, 0, 1);
    bit_row("t3", 1, 0, 0, 1, 1, 0, 1);
    bit_row("t3", 0, 1, 0, 1, 1, 0, 1);
    bit_row("t3", 1, 1, 0, 1, 1, 0, 1);
    bit_row("t3", 0, 0, 0, 1, 1, 0, 1);
    bit_row("t3", 1, 1, 1, 2, 2, 0, 1);
    bit_row("t3", 0, 1, 0, 2, 2, 0, 1);
    bit_row("t3", 1, 0, 0, 2, 2, 0, 1);
    bit_row("t3", 0, 0, 0, 2, 2, 0, 1);
    bit_row("t3", 1, 1, 0, 2, 2, 0, 1);
    bit_row("t3", 0, 0, 0, 2, 2, 0, 1);
    bit_row("t3", 1, 1, 1, 3, 3, 0, 1);
    bit_row("t3", 0, 0, 0, 3, 3, 0, 1);
    bit_row("t3", 1, 0, 0, 3, 3, 0, 1);
    bit_row("t3", 1, 1, 0, 3, 3, 0, 1);
    add("t3_ld_drop", 1, 1, 8'h0B, 4'd4, 1, 1, 1, 0, 0, 3, 3, 0, 1);
    bit_row("t3_cleared", 1, 0, 0, 3, 3, 0, 1);
    bit_row("t3_cleared", 1, 1, 0, 3, 3, 0, 1);
    bit_row("t3_cleared", 1, 1, 0, 3, 3, 0, 1);
    add("t4_len1", 1, 1, 8'h0B, 4'd1, 1, 0, 0, 0, 0, 3, 3, 1, 0);
    add("t4_len0", 1, 1, 8'h0B, 4'd0, 1, 0, 0, 0, 0, 3, 3, 1, 0);
    add("t4_len9", 1, 1, 8'h0B, 4'd9, 1, 0, 0, 0, 0, 3, 3, 1, 0);
    run_table();

    // Unconfigured detector must ignore arbitrary data.
    for (int i = 0; i < 20; i++) begin
      vec_t r;
      r.tag = "t4_rand"; r.rst_n = 1; r.ld = 0; r.pat = 8'h00; r.len = 4'd0; r.ovl = 0;
      r.v = 1; r.din = logic'($urandom_range(0, 1)); r.clr = 0;
      r.e_out = 0; r.e_cnt8 = 3; r.e_cnt2 = 3; r.e_err = 1; r.e_arm = 0;
      apply(r);
    end

    // Recovery, counter saturation, clear-with-match, full length, reset mid-stream.
    add("t4_load3", 1, 1, 8'hFD, 4'd3, 1, 0, 0, 0, 0, 3, 3, 0, 1);
    bit_row("t4_b", 1, 1, 0, 3, 3, 0, 1);
    bit_row("t4_b", 1, 0, 0, 3, 3, 0, 1);
    bit_row("t4_b", 1, 1, 1, 4, 3, 0, 1);
    add("t5_load", 1, 1, 8'h03, 4'd2, 1, 0, 0, 1, 0, 0, 0, 0, 1);
    bit_row("t5", 1, 1, 0, 0, 0, 0, 1);
    bit_row("t5", 1, 1, 1, 1, 1, 0, 1);
    bit_row("t5", 1, 1, 1, 2, 2, 0, 1);
    bit_row("t5", 1, 1, 1, 3, 3, 0, 1);
    bit_row("t5", 1, 1, 1, 4, 3, 0, 1);
    bit_row("t5", 1, 1, 1, 5, 3, 0, 1);
    add("t5_clr_match", 1, 0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 1, 1, 0, 1);
    add("t5_clr_idle",  1, 0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    add("len8_load", 1, 1, 8'hA5, 4'd8, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    bit_row("len8", 1, 1, 0, 0, 0, 0, 1);
    bit_row("len8", 1, 0, 0, 0, 0, 0, 1);
    bit_row("len8", 1, 1, 0, 0, 0, 0, 1);
    bit_row("len8", 1, 0, 0, 0, 0, 0, 1);
    bit_row("len8", 1, 0, 0, 0, 0, 0, 1);
    bit_row("len8", 1, 1, 0, 0, 0, 0, 1);
    bit_row("len8", 1, 0, 0, 0, 0, 0, 1);
    bit_row("len8", 1, 1, 1, 1, 1, 0, 1);
    add("t6_load", 1, 1, 8'h0B, 4'd4, 1, 0, 0, 0, 0, 1, 1, 0, 1);
    bit_row("t6", 1, 1, 0, 1, 1, 0, 1);
    bit_row("t6", 1, 0, 0, 1, 1, 0, 1);
    bit_row("t6", 1, 1, 0, 1, 1, 0, 1);
    bit_row("t6", 1, 1, 1, 2, 2, 0, 1);
    bit_row("t6", 1, 1, 0, 2, 2, 0, 1);
    bit_row("t6", 1, 0, 0, 2, 2, 0, 1);
    add("t6_rst", 0, 1, 8'h0B, 4'd4, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    bit_row("t6_after", 1, 1, 0, 0, 0, 0, 0);
    bit_row("t6_after", 1, 0, 0, 0, 0, 0, 0);
    bit_row("t6_after", 1, 1, 0, 0, 0, 0, 0);
    bit_row("t6_after", 1, 1, 0, 0, 0, 0, 0);
    run_table();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
